mem_refill_arbiter: RTL and testbench
=====================================

# mem_refill_arbiter

Parametrised miss-service engine between N direct-mapped line caches and the single unified main memory. Each cache raises a miss request. The block picks one requester round-robin, writes back the dirty victim line if there is one, then fetches the missing line and hands it back with a one-cycle fill strobe. It generalises the fixed two-cache (I/D) memory hierarchy to any channel count, line width and address width, and adds fair arbitration and write-back-then-fill sequencing.

## Interface
Parameters:
- NCH, 2: number of requesting caches (≥2)
- ADDR_W, 14: line-address width (memory word = one line)
- LINE_W, 64: line width in bits

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NCH  per-channel miss request, level, held until that channel's done
- dirty  in  NCH  victim line of channel is dirty; sampled at grant
- fill_addr  in  NCH*ADDR_W  line address to fetch; channel k at [k*ADDR_W +: ADDR_W]
- wb_addr  in  NCH*ADDR_W  victim line address, same packing
- wb_data  in  NCH*LINE_W  victim line data; channel k at [k*LINE_W +: LINE_W]
- grant  out  NCH  one-hot: channel being serviced; 0 when idle
- busy  out  1  state ≠ IDLE
- fill_we  out  NCH  one-hot, one-cycle pulse: write fill_data into channel's cache, clear dirty
- fill_data  out  LINE_W  fetched line; valid only while fill_we ≠ 0
- done  out  NCH  equal to fill_we; requester drops req at the end of this cycle
- m_addr  out  ADDR_W  memory line address
- m_re  out  1  memory read strobe
- m_we  out  1  memory write strobe
- m_wdata  out  LINE_W  memory write data
- m_rd_data  in  LINE_W  memory read data, valid when m_rdy=1
- m_rdy  in  1  memory completes the current operation this cycle

## Operation
- States: IDLE, WB, FILL, DONE.
- IDLE: if req≠0, select channel c = first requester at or after pointer ptr (wrapping modulo NCH). Latch c, dirty[c], fill_addr[c], wb_addr[c], wb_data[c]. Next state is WB if dirty[c], else FILL. Request inputs are not re-sampled until the next IDLE.
- WB: m_we=1, m_addr=latched wb_addr, m_wdata=latched wb_data. Hold until m_rdy=1, then go to FILL.
- FILL: m_re=1, m_addr=latched fill_addr. Hold until m_rdy=1, then capture m_rd_data into fill_data and go to DONE.
- DONE: fill_we[c]=done[c]=1 for exactly one cycle. ptr ← (c+1) mod NCH. Next state is IDLE.
- m_re and m_we are never both high. Both are 0 in IDLE and DONE. m_rdy is ignored in IDLE and DONE.
- grant[c]=1 in WB, FILL and DONE.
- m_addr, m_wdata and grant stay constant for the whole of a memory operation.
- Deasserting req mid-service is a protocol violation. The block still completes the service and pulses done.
- Reset: state ← IDLE, ptr ← 0. All outputs read 0 (grant, busy, fill_we, fill_data, done, m_addr, m_re, m_we, m_wdata).
- Reset during WB or FILL abandons the transaction: no done, and the strobes are low in the cycle after the reset edge. Main memory must be reset together with this block.

## Timing
- Req high at cycle 0 in IDLE → WB/FILL state at cycle 1, with strobe and grant visible at cycle 1.
- A clean miss with m_rdy at cycle t → done/fill_we at cycle t+1 → IDLE at t+2. The earliest new grant is at cycle t+3 (strobe visible).
- Minimum clean miss: req c0, m_re c1 (m_rdy c1), done c2.
- Dirty miss: WB m_rdy at cycle t → m_re at t+1. No gap cycle.
- A requester that clears req on the edge after done is not re-granted. IDLE sees the new value.
- Fairness: under continuous requests from all channels, service order is 0,1,…,NCH-1,0,… Worst-case wait is NCH-1 services.

## Test plan
- Reset: hold rst 2 cycles with req=2'b11 and m_rdy=1 → all outputs 0. Release with req=2'b01, dirty=0 → cycle 1: grant=01, m_re=1, m_we=0.
- Clean fill ch0: fill_addr=14'h0123, m_rdy 4 cycles after m_re with m_rd_data=64'hDEAD_BEEF_0123_4567 → m_addr=14'h0123 throughout, fill_we=done=01 one cycle later with that data, busy low the following cycle.
- Dirty fill ch1: wb_addr=14'h2A00, wb_data=64'h1111_2222_3333_4444, fill_addr=14'h0A00 → m_we with 14'h2A00/wb_data until m_rdy, next cycle m_re with 14'h0A00, then done=10.
- Fairness: req=2'b11 from reset, each requester re-raising req 1 cycle after its done, m_rdy after 2 cycles → grant order 01,10,01,10. No channel served twice in a row while the other waits.
- Reset mid-WB: rst asserted while m_we=1 → next cycle m_we=0, grant=0, busy=0, no done pulse. After release, req=2'b10 is granted (ptr=0, ch0 idle).
- Spurious m_rdy: pulse m_rdy in IDLE with req=0, and during DONE → no state change, no extra fill_we.

Source files
------------

// File: rtl/mem_refill_arbiter_if.sv
// mem_refill_arbiter_if: cache-side miss handshake plus main-memory bus for mem_refill_arbiter.
// Cache side: req, dirty, fill_addr, wb_addr and wb_data come in, packed per channel.
// grant, busy, fill_we, fill_data and done go back to the caches.
// Memory side: the arbiter drives m_addr, m_re, m_we and m_wdata.
// The memory returns m_rd_data and m_rdy.
// The arbiter connects through modport master; the caches and memory connect through modport slave.
interface mem_refill_arbiter_if #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 14,
    parameter int LINE_W = 64
);
    logic [NCH-1:0]        req;
    logic [NCH-1:0]        dirty;
    logic [NCH*ADDR_W-1:0] fill_addr;
    logic [NCH*ADDR_W-1:0] wb_addr;
    logic [NCH*LINE_W-1:0] wb_data;
    logic [NCH-1:0]        grant;
    logic                  busy;
    logic [NCH-1:0]        fill_we;
    logic [LINE_W-1:0]     fill_data;
    logic [NCH-1:0]        done;
    logic [ADDR_W-1:0]     m_addr;
    logic                  m_re;
    logic                  m_we;
    logic [LINE_W-1:0]     m_wdata;
    logic [LINE_W-1:0]     m_rd_data;
    logic                  m_rdy;

    modport master (
        input  req, dirty, fill_addr, wb_addr, wb_data, m_rd_data, m_rdy,
        output grant, busy, fill_we, fill_data, done, m_addr, m_re, m_we, m_wdata
    );

    modport slave (
        output req, dirty, fill_addr, wb_addr, wb_data, m_rd_data, m_rdy,
        input  grant, busy, fill_we, fill_data, done, m_addr, m_re, m_we, m_wdata
    );
endinterface

// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: round-robin miss service for NCH direct-mapped caches over one main memory.
// clk, rst: rising-edge clock, synchronous active-high reset.
// bus (master): per-channel miss requests, victim/fill info, one-hot grant/fill/done, memory bus.
// A serviced request writes back the dirty victim first, then fetches the line.
// The fetched line is returned to the cache with a one-cycle fill_we/done strobe.
module mem_refill_arbiter #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 14,
    parameter int LINE_W = 64
) (
    input logic                  clk,
    input logic                  rst,
    mem_refill_arbiter_if.master bus
);
    localparam int CW = $clog2(NCH);

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     ch_q, ch_d;
    logic [ADDR_W-1:0] fa_q, fa_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [LINE_W-1:0] wd_q, wd_d;
    logic [LINE_W-1:0] fd_q, fd_d;
    logic [CW-1:0]     pick;
    logic [NCH-1:0]    ch_oh;
    int                idx;

    // Scan from the farthest offset down to the pointer so the closest requester wins last.
    always_comb begin
        pick = ptr_q;
        idx  = 0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            idx = (idx >= NCH) ? idx - NCH : idx;
            if (bus.req[CW'(idx)]) pick = CW'(idx);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ch_d    = ch_q;
        fa_d    = fa_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        fd_d    = fd_q;
        case (state_q)
            IDLE: if (|bus.req) begin
                ch_d    = pick;
                fa_d    = bus.fill_addr[int'(pick) * ADDR_W +: ADDR_W];
                wa_d    = bus.wb_addr[int'(pick) * ADDR_W +: ADDR_W];
                wd_d    = bus.wb_data[int'(pick) * LINE_W +: LINE_W];
                state_d = bus.dirty[pick] ? WB : FILL;
            end
            WB: state_d = bus.m_rdy ? FILL : WB;
            FILL: if (bus.m_rdy) begin
                fd_d    = bus.m_rd_data;
                state_d = DONE;
            end
            DONE: begin
                ptr_d   = (ch_q == CW'(NCH - 1)) ? '0 : ch_q + CW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            ch_q    <= '0;
            fa_q    <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
            fd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
            fa_q    <= fa_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            fd_q    <= fd_d;
        end
    end

    // Every output depends only on registered state.
    // Grant, address and write data therefore cannot move during a memory operation.
    assign ch_oh         = NCH'(1) << ch_q;
    assign bus.grant     = (state_q == IDLE) ? '0 : ch_oh;
    assign bus.busy      = state_q != IDLE;
    assign bus.fill_we   = (state_q == DONE) ? ch_oh : '0;
    assign bus.done      = (state_q == DONE) ? ch_oh : '0;
    assign bus.fill_data = fd_q;
    assign bus.m_we      = state_q == WB;
    assign bus.m_re      = state_q == FILL;
    assign bus.m_addr    = (state_q == WB) ? wa_q : (state_q == FILL) ? fa_q : '0;
    assign bus.m_wdata   = (state_q == WB) ? wd_q : '0;
endmodule

// File: tb/tb_mem_refill_arbiter.sv
// tb_mem_refill_arbiter: randomized scoreboard bench for mem_refill_arbiter.
module tb_mem_refill_arbiter;
    localparam int NCH = 2;
    localparam int AW  = 14;
    localparam int LW  = 64;

    typedef struct {
        int             kind;
        int             st;
        int             cy;
        int             ch;
        logic [AW-1:0]  addr;
        logic [LW-1:0]  data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_refill_arbiter_if #(.NCH(NCH), .ADDR_W(AW), .LINE_W(LW)) bus ();
    mem_refill_arbiter #(.NCH(NCH), .ADDR_W(AW), .LINE_W(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;
    ev_t exp_q[$];

    int free_c, ptr_m, cur, busy_lo, wb_rdy, fill_rdy, done_c;
    int clr_c [NCH];
    logic [NCH-1:0] pend;
    logic [LW-1:0] fill_val;
    logic [NCH-1:0] dv;
    logic [AW-1:0] fa [NCH];
    logic [AW-1:0] wa [NCH];
    logic [LW-1:0] wd [NCH];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [LW-1:0] rnd_line();
        return LW'({$urandom(), $urandom()});
    endfunction

    function automatic ev_t mk(input int kind, input int st, input int cy, input int ch,
                               input logic [AW-1:0] a, input logic [LW-1:0] d);
        ev_t e;
        e.kind = kind;
        e.st = st;
        e.cy = cy;
        e.ch = ch;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    // Cycles until m_rdy, counted from the first cycle of the memory operation.
    function automatic int lat(input int mode);
        return (mode == 1) ? 2 : (mode == 2) ? 5 : (mode == 4) ? 8 : int'($urandom_range(1, 4));
    endfunction

    // Monitor: kind 0 = write-back, 1 = fill read, 2 = done strobe, 3 = idle.
    always @(negedge clk) begin : mon
        ev_t e;
        int kd;
        logic [NCH-1:0] oh, fw;
        logic [3*NCH+2:0] exp_s, act_s;
        if (mon_en) begin
            kd = 3;
            e = mk(3, 0, 0, 0, '0, '0);
            if (exp_q.size() > 0 && exp_q[0].st <= cyc) begin
                e = exp_q[0];
                kd = e.kind;
            end
            oh = (kd == 3) ? '0 : NCH'(1) << e.ch;
            fw = (kd == 2) ? oh : '0;
            exp_s = {oh, kd != 3, kd == 0, kd == 1, fw, fw};
            act_s = {bus.grant, bus.busy, bus.m_we, bus.m_re, bus.fill_we, bus.done};
            checks++;
            if (act_s !== exp_s) begin
                failures++;
                $display("FAIL ctrl cycle=%0d phase=%0d grant,busy,m_we,m_re,fill_we,done got=%b expected=%b",
                         cyc, kd, act_s, exp_s);
            end
            if (kd == 0 || kd == 1) begin
                checks++;
                if (bus.m_addr !== e.addr || (kd == 0 && bus.m_wdata !== e.data)) begin
                    failures++;
                    $display("FAIL membus cycle=%0d phase=%0d m_addr got=%h expected=%h m_wdata got=%h expected=%h",
                             cyc, kd, bus.m_addr, e.addr, bus.m_wdata, e.data);
                end
            end
            if (kd == 2) begin
                checks++;
                if (bus.fill_data !== e.data) begin
                    failures++;
                    $display("FAIL fill_data cycle=%0d ch=%0d got=%h expected=%h", cyc, e.ch, bus.fill_data, e.data);
                end
            end
            if (kd != 3 && cyc == e.cy) void'(exp_q.pop_front());
        end
    end

    // One clock of stimulus. The reference model predicts the whole service at the moment
    // the arbiter samples the requests.
    task automatic step(input int mode, input bit allow);
        int k, c, lw, lf;
        bit want;
        @(posedge clk);
        #1;
        k = cyc;
        if (rst) begin
            rst = 1'b0;
            free_c = k;
            ptr_m = 0;
            mon_en = 1'b1;
        end
        if (k == done_c + 1) begin
            pend[cur] = 1'b0;
            clr_c[cur] = k;
        end
        for (int i = 0; i < NCH; i++) begin
            dv[i] = 1'($urandom);
            fa[i] = AW'($urandom);
            wa[i] = AW'($urandom);
            wd[i] = rnd_line();
            want = (mode == 0) ? ($urandom_range(0, 3) == 0) : (mode == 1) ? 1'b1 :
                   (i == ((mode == 2 || mode == 4) ? 0 : 1));
            if (allow && !pend[i] && k > clr_c[i] && want) pend[i] = 1'b1;
        end
        if (mode == 2) begin
            dv[0] = 1'b0;
            fa[0] = 14'h0123;
        end
        if (mode == 3) begin
            dv[1] = 1'b1;
            wa[1] = 14'h2A00;
            wd[1] = 64'h1111_2222_3333_4444;
            fa[1] = 14'h0A00;
        end
        if (mode == 4) dv[0] = 1'b1;
        bus.req = pend;
        bus.dirty = dv;
        for (int i = 0; i < NCH; i++) begin
            bus.fill_addr[i*AW +: AW] = fa[i];
            bus.wb_addr[i*AW +: AW] = wa[i];
            bus.wb_data[i*LW +: LW] = wd[i];
        end
        if (k == free_c) begin
            if (pend != '0) begin
                c = -1;
                for (int i = 0; i < NCH; i++)
                    if (c < 0 && pend[(ptr_m + i) % NCH]) c = (ptr_m + i) % NCH;
                cur = c;
                lw = dv[c] ? lat(mode) : 0;
                lf = lat(mode);
                busy_lo = k + 1;
                wb_rdy = dv[c] ? k + lw : -10;
                fill_rdy = k + lw + lf;
                done_c = fill_rdy + 1;
                free_c = done_c + 1;
                ptr_m = (c + 1) % NCH;
                fill_val = (mode == 2) ? 64'hDEAD_BEEF_0123_4567 : rnd_line();
                if (dv[c]) exp_q.push_back(mk(0, k + 1, wb_rdy, c, wa[c], wd[c]));
                exp_q.push_back(mk(1, k + lw + 1, fill_rdy, c, fa[c], '0));
                exp_q.push_back(mk(2, done_c, done_c, c, '0, fill_val));
            end else begin
                free_c = k + 1;
            end
        end
        bus.m_rdy = (k == wb_rdy || k == fill_rdy) ? 1'b1 :
                    (k >= busy_lo && k < fill_rdy) ? 1'b0 : 1'($urandom);
        bus.m_rd_data = (k == fill_rdy) ? fill_val : rnd_line();
    endtask

    task automatic drain(input int mode);
        int n = 0;
        while ((pend != '0 || exp_q.size() != 0) && n < 300) begin
            step(mode, 1'b0);
            n++;
        end
        checks++;
        if (pend != '0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain mode=%0d pending=%b queued=%0d expected all serviced", mode, pend, exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d expected completion before time limit", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3*NCH+2*LW+AW+1:0] outs;
        pend = '0;
        cur = 0;
        busy_lo = 0;
        wb_rdy = -10;
        fill_rdy = -10;
        done_c = -10;
        free_c = 0;
        ptr_m = 0;
        fill_val = '0;
        for (int i = 0; i < NCH; i++) clr_c[i] = -1;
        bus.req = '1;
        bus.dirty = '1;
        bus.fill_addr = '0;
        bus.wb_addr = '0;
        bus.wb_data = '0;
        bus.m_rd_data = '1;
        bus.m_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        outs = {bus.grant, bus.busy, bus.fill_we, bus.done, bus.m_re, bus.m_we,
                bus.m_addr, bus.m_wdata, bus.fill_data};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h expected=0", outs);
        end
        step(2, 1'b1);
        drain(2);
        step(3, 1'b1);
        drain(3);
        repeat (40) step(1, 1'b1);
        drain(1);
        repeat (600) step(0, 1'b1);
        drain(0);
        step(4, 1'b1);
        step(4, 1'b0);
        step(4, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b0;
        pend = '0;
        bus.req = '0;
        bus.m_rdy = 1'b1;
        exp_q.delete();
        done_c = -10;
        wb_rdy = -10;
        fill_rdy = -10;
        busy_lo = 0;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.m_we, bus.m_re, bus.busy, bus.grant, bus.done, bus.fill_we} !== '0) begin
            failures++;
            $display("FAIL reset_abandon m_we=%b m_re=%b busy=%b grant=%b done=%b fill_we=%b expected all 0",
                     bus.m_we, bus.m_re, bus.busy, bus.grant, bus.done, bus.fill_we);
        end
        step(5, 1'b1);
        drain(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
